// File: rtl/mips_fetch_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
//   Shared types and constants for the instruction fetch front-end.
//   - DEF_ADDR_W / DEF_INSTR_W : default PC and instruction widths
//   - PC_INCR                  : byte distance between sequential fetches
//   - fetch_state_t            : fetch sequencer states
//   - fetch_entry_t            : one buffered instruction tagged with its PC
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int PC_INCR     = 4;

  typedef enum logic [1:0] {
    FETCH_RESET = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous in-order FIFO of fetch_entry_t. Flush empties the FIFO and
//   takes priority over push and pop in the same cycle.
//   Ports:
//     clock, reset_n      : rising-edge clock, synchronous active-low reset
//     push, push_data     : write one entry (must not be full unless flushing)
//     pop                 : remove the head entry (ignored when empty)
//     flush               : discard all entries
//     head                : entry at the head (valid when !empty)
//     count, empty, full  : occupancy status
// -----------------------------------------------------------------------------
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observable
  // through the pointers/count, which are, so resetting the array would only
  // add reset fan-out.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  overflow_chk : assert property (@(posedge clock) disable iff (!reset_n)
    !(push && full && !flush));

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front-end. Issues sequential word-aligned fetch requests
//   to an in-order, variable-latency instruction memory, buffers the returned
//   instructions with their PCs, and hands them to the datapath one per
//   valid/ready handshake. A redirect flushes the buffer and drops every
//   response still in flight for the old path.
//
//   Optional build macro: FETCH_PERF_COUNTERS_EN adds perf_fetched and
//   perf_dropped (32-bit saturating counters).
//
//   Ports:
//     clock, reset_n                   : clock, synchronous active-low reset
//     imem_req_valid/ready/addr        : fetch request channel
//     imem_rsp_valid/data              : in-order response, no backpressure
//     instr_valid/ready/data/pc        : instruction stream to the datapath
//     redirect_valid, redirect_pc      : one-cycle branch/jump redirect
//     perf_fetched, perf_dropped       : (optional) response counters
// -----------------------------------------------------------------------------
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] INCR     = ADDR_W'(PC_INCR);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(PC_INCR - 1);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] redirect_target;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  drop_cnt_next;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              req_hs;
  logic              rsp_keep;
  logic              rsp_drop;
  logic              fifo_empty;
  logic              fifo_full;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // Credits cover both buffered entries and requests whose responses have not
  // yet returned, so a returning response always finds a free FIFO slot.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = (state != FETCH_RESET) && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  // A response landing in a redirect cycle belongs to the old path.
  assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign rsp_drop = imem_rsp_valid && !redirect_valid && (drop_cnt != '0);

  assign outstanding_next = outstanding + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);
  assign redirect_target  = redirect_pc & ~LOW_MASK;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    drop_cnt_next = drop_cnt;
    state_next    = state;
    if (redirect_valid) begin
      // Everything still in flight after this cycle (including a request
      // accepted right now) was fetched for the old path.
      drop_cnt_next = outstanding_next;
      state_next    = (outstanding_next != '0) ? FETCH_DRAIN : FETCH_RUN;
    end else begin
      if (rsp_drop) drop_cnt_next = drop_cnt - CNT_W'(1);
      case (state)
        FETCH_RESET: state_next = FETCH_RUN;
        FETCH_RUN:   state_next = FETCH_RUN;
        FETCH_DRAIN: if (drop_cnt_next == '0) state_next = FETCH_RUN;
        default:     state_next = FETCH_RESET;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= FETCH_RESET;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
      end else begin
        if (req_hs)   fetch_pc <= fetch_pc + INCR;
        if (rsp_keep) rsp_pc   <= rsp_pc + INCR;
      end
    end
  end

  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (instr_valid && instr_ready),
    .flush     (redirect_valid),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Outputs read zero whenever nothing is buffered, which also gives the
  // required zero values right after reset without resetting FIFO storage.
  assign instr_valid = !fifo_empty;
  assign instr_data  = fifo_empty ? '0 : head_entry.instr;
  assign instr_pc    = fifo_empty ? '0 : head_entry.pc;

  credit_chk : assert property (@(posedge clock) disable iff (!reset_n)
    rsp_keep |-> !fifo_full);

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (rsp_keep && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (rsp_drop && (perf_dropped != '1)) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Randomised bench for fetch_unit. A behavioural memory answers requests in
//   order with configurable latency. A transaction-level model tags each
//   request with the path (epoch) it was fetched on; responses from an older
//   epoch, or arriving in a redirect cycle, are expected to vanish, the rest
//   are expected on instr_* in order. A monitor pops the expectation queue on
//   every output handshake.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  fetch_unit #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // ---------------- stimulus knobs ----------------
  int p_ready  = 100;
  int p_mready = 100;
  int p_redir  = 0;
  int lat_min  = 1;
  int lat_max  = 1;

  // ---------------- instruction memory ----------------
  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  mem_req_t mem_q[$];
  int       mem_cycle = 0;
  int       last_due  = 0;
  logic     mem_rst;

  initial begin
    forever begin
      @(negedge clock);
      mem_rst = !reset_n;
      if (!mem_rst && imem_req_valid && imem_req_ready) begin
        int due;
        due = mem_cycle + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{addr: imem_req_addr, due: due});
      end
      @(posedge clock);
      mem_cycle++;
      if (mem_rst) begin
        mem_q.delete();
        last_due = mem_cycle;
      end
      #1;
      if (mem_q.size() > 0 && mem_q[0].due <= mem_cycle) begin
        mem_req_t m;
        m = mem_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(m.addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; int epoch; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  out_t        out_q[$];
  exp_t        exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  int          epoch = 0;
  bit          live = 0;
  bit          model_running = 0;
  int          req_count = 0;
  logic [31:0] m_fetched = '0;
  logic [31:0] m_dropped = '0;

  logic        s_rst, s_req, s_rsp, s_redir;
  logic [31:0] s_rpc;

  initial begin
    forever begin
      @(negedge clock);
      s_rst   = !reset_n;
      s_req   = imem_req_valid && imem_req_ready;
      s_rsp   = imem_rsp_valid;
      s_redir = redirect_valid;
      s_rpc   = redirect_pc;
      if (live && !s_rst && s_req) check("req_addr", imem_req_addr, model_pc);
      @(posedge clock);
      if (s_rst) begin
        exp_q.delete();
        out_q.delete();
        model_pc      = RESET_PC;
        model_running = 0;
        live          = 1;
        epoch++;
        m_fetched = '0;
        m_dropped = '0;
      end else begin
        model_running = 1;
        if (s_rsp && out_q.size() > 0) begin
          out_t r;
          r = out_q.pop_front();
          if (!s_redir && r.epoch == epoch) begin
            exp_q.push_back('{pc: r.addr, data: mem_word(r.addr)});
            m_fetched++;
          end else if (!s_redir) begin
            m_dropped++;
          end
        end
        if (s_req) begin
          out_q.push_back('{addr: model_pc, epoch: epoch});
          model_pc += 32'd4;
          req_count++;
        end
        if (s_redir) begin
          exp_q.delete();
          epoch++;
          model_pc = s_rpc & ~32'd3;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (live) begin
        check("req_valid", imem_req_valid,
              model_running && (exp_q.size() + out_q.size() < DEPTH));
        check("instr_valid", instr_valid, exp_q.size() != 0);
        if (instr_valid && instr_ready && exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr_data", instr_data, e.data);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive_knobs();
    instr_ready    = ($urandom_range(99) < p_ready);
    imem_req_ready = ($urandom_range(99) < p_mready);
    redirect_valid = ($urandom_range(99) < p_redir);
    redirect_pc    = $urandom;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clock); #2;
      drive_knobs();
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clock); #2;
    drive_knobs();
    redirect_valid = 1'b1;
    redirect_pc    = pc;
  endtask

  task automatic reset_checks();
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr_data", instr_data, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
`ifdef FETCH_PERF_COUNTERS_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_dropped", perf_dropped, 32'h0);
`endif
  endtask

  task automatic apply_reset(input int n);
    @(posedge clock); #2;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    repeat (n) @(posedge clock);
    @(negedge clock);
    reset_checks();
    @(posedge clock); #2;
    reset_n = 1'b1;
  endtask

  task automatic perf_checks(input string tag);
`ifdef FETCH_PERF_COUNTERS_EN
    @(negedge clock);
    check({tag, "_perf_fetched"}, perf_fetched, m_fetched);
    check({tag, "_perf_dropped"}, perf_dropped, m_dropped);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  req0;
    bit  hit;

    // Streaming at latency 1 with an always-ready consumer.
    p_ready = 100; p_mready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
    apply_reset(2);
    run_cycles(20);

    // Stalled consumer: exactly DEPTH requests, then the credit limit holds.
    instr_ready = 1'b0;
    p_ready = 0;
    apply_reset(1);
    req0 = req_count;
    run_cycles(10);
    @(negedge clock);
    check("stall_req_count", req_count - req0, DEPTH);
    check("stall_req_blocked", imem_req_valid, 1'b0);
    p_ready = 100;
    run_cycles(15);

    // Redirect with three requests in flight at latency 3.
    lat_min = 3; lat_max = 3;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      run_cycles(1);
      if (out_q.size() >= 3) hit = 1;
    end
    check("three_outstanding_seen", hit, 1'b1);
    do_redirect(32'h0000_0100);
    run_cycles(20);
    perf_checks("redirect");

    // Redirect coinciding with a response and a request handshake.
    lat_min = 1; lat_max = 1;
    run_cycles(5);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge clock); #2;
      drive_knobs();
      if (imem_rsp_valid && imem_req_valid && imem_req_ready) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        hit = 1;
      end
    end
    check("coincident_redirect_seen", hit, 1'b1);
    run_cycles(15);

    // Misaligned target is forced to a word boundary.
    do_redirect(32'h0000_0203);
    run_cycles(1);
    @(negedge clock);
    check("redirect_align", imem_req_addr, 32'h0000_0200);
    run_cycles(10);

    // Fetch address wraps past the top of the address space.
    do_redirect(32'hFFFF_FFF3);
    run_cycles(20);

    // Randomised traffic with backpressure, latency jitter and redirects.
    p_ready = 60; p_mready = 70; p_redir = 5; lat_min = 1; lat_max = 5;
    run_cycles(800);
    p_redir = 0;
    run_cycles(5);
    perf_checks("random");

    // Reset in the middle of traffic.
    apply_reset(1);
    p_ready = 100; p_mready = 100; lat_min = 1; lat_max = 2;
    run_cycles(30);

    // Drain and compare final counters.
    run_cycles(20);
    perf_checks("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front-end that sits directly upstream of the single-cycle decode/execute datapath and feeds it one instruction per handshake.
- Generates sequential word addresses and issues them to an instruction memory over a request/response interface with variable latency.
- Buffers returned instructions, tagged with their PC, in a small in-order FIFO.
- Accepts branch/jump redirects from the datapath: flushes buffered instructions and discards responses still in flight for the old path.

Parameters:
- ADDR_W, 32, PC/address width.
- INSTR_W, 32, instruction width.
- DEPTH, 4, FIFO entries; also the limit on (FIFO occupancy + outstanding requests).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  byte address, word aligned.
- imem_rsp_valid  in  1  response valid; in order; no backpressure.
- imem_rsp_data  in  INSTR_W  returned instruction.
- instr_valid  out  1  instruction available to datapath.
- instr_ready  in  1  datapath consumes instruction.
- instr_data  out  INSTR_W  instruction.
- instr_pc  out  ADDR_W  PC of instr_data.
- redirect_valid  in  1  one-cycle redirect pulse.
- redirect_pc  in  ADDR_W  new fetch target; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (reset_n=0 at posedge):
  - imem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0.
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - FIFO empty; outstanding=0, drop_cnt=0; state=FETCH_RESET.
  - A reset mid-operation discards everything. Responses to pre-reset requests are the memory's responsibility; the memory is reset together with this block.
- State machine:
  - FETCH_RESET -> FETCH_RUN on the first cycle with reset_n=1.
  - FETCH_RUN -> FETCH_DRAIN on a redirect when computed drop_cnt>0.
  - FETCH_DRAIN -> FETCH_RUN when drop_cnt reaches 0 with no new redirect.
  - A redirect in FETCH_DRAIN reloads drop_cnt and stays in FETCH_DRAIN, or goes to FETCH_RUN if the reloaded value is 0.
- Request issue:
  - imem_req_valid = (state!=FETCH_RESET) && (fifo_count + outstanding < DEPTH). It is registered-free but depends only on state, never on redirect_valid.
  - imem_req_addr = fetch_pc.
  - On a request handshake, fetch_pc += 4 (wraps modulo 2^ADDR_W) and outstanding += 1.
  - Requests are allowed in FETCH_DRAIN.
- Responses:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0 the response is discarded and drop_cnt -= 1.
  - Otherwise {rsp_pc, imem_rsp_data} is pushed into the FIFO and rsp_pc += 4.
  - The credit rule guarantees the FIFO never overflows; a push to a full FIFO is an assertion failure.
- Output:
  - instr_valid = FIFO non-empty; instr_data/instr_pc come from the FIFO head.
  - Pop on instr_valid && instr_ready.
  - Latency: a response is visible on instr_* the cycle after imem_rsp_valid (no bypass).
  - A response and a pop in the same cycle leave the FIFO count unchanged.
- Redirect (redirect_valid=1 at posedge) has priority over all other updates:
  - fetch_pc = rsp_pc = {redirect_pc[ADDR_W-1:2],2'b00}; FIFO cleared.
  - drop_cnt = outstanding + req_handshake_this_cycle − rsp_valid_this_cycle, plus the old drop_cnt already included in outstanding.
  - A response arriving in the redirect cycle is discarded.
  - A request accepted in the redirect cycle belongs to the old path and is counted for dropping.
  - A pop in the same cycle counts as delivered.
- Width rules: outstanding and drop_cnt are $clog2(DEPTH+1) bits; fifo_count is the same width.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- When defined, adds two output ports:
  - perf_fetched (32 bits): counts accepted, non-dropped responses.
  - perf_dropped (32 bits): counts discarded responses.
- Both counters reset to 0, saturate at 32'hFFFF_FFFF, and hold during redirect.
- When not defined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package mips_fetch_pkg:
  - ADDR_W and INSTR_W defaults; PC_INCR=4.
  - Enum fetch_state_t {FETCH_RESET, FETCH_RUN, FETCH_DRAIN}.
  - Struct fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH; ports push/pop/flush, count, empty, full.
  - Flush has priority over push.

Test Plan:
- Reset release, memory latency 1, instr_ready=1 → requests to 0x0, 0x4, 0x8…; first instr_valid with instr_pc=0x0 two cycles after the first request handshake; one instruction per cycle thereafter.
- instr_ready=0 for 10 cycles, latency 1 → exactly 4 requests issued, FIFO full, imem_req_valid=0; after instr_ready=1, instructions drain in order 0x0..0xC and fetching resumes at 0x10.
- Memory latency 3 with 3 requests outstanding; redirect to 0x100 → 3 responses dropped (state FETCH_DRAIN); first delivered instr_pc=0x100 with data from address 0x100.
- Redirect in the same cycle as imem_rsp_valid and a request handshake → that response is dropped, the new request is counted in drop_cnt, and no stale PC ever appears on instr_pc.
- redirect_pc=0x203 → next imem_req_addr=0x200; fetch_pc=0xFFFF_FFFC increments and wraps to 0x0.
- With FETCH_PERF_COUNTERS_EN defined, after the redirect scenario → perf_dropped=3 and perf_fetched equals the delivered count; reset_n=0 mid-stream clears the counters, FIFO and outputs on the next edge.
